burst_rw_sched: RTL and testbench
=================================

Name: burst_rw_sched

Overview:
- Parametrised CAS-to-data timing scheduler for the DDR4 controller data path.
- Every accepted CAS (read or write) is queued with its own latency, captured when the CAS is accepted.
- Each command's data burst is launched exactly rd_delay/wr_delay cycles after its CAS.
- Supports pipelined CAS, BL8/BC4 burst lengths, seamless back-to-back bursts, late-launch and overflow error flags.

Parameters:
DEPTH, 8, max outstanding CAS commands (power of 2, 2..32)
DELAY_W, 6, width of latency inputs and per-entry countdown
CNT_W, 4, width of q_count (must hold DEPTH)

Ports:
clock_t  in  1  controller clock (data-bus clock, one beat pair per cycle)
reset  in  1  synchronous active-high reset
cas_rdy  in  1  one-cycle pulse: CAS issued this cycle
cas_rw  in  1  1=READ, 0=WRITE for the CAS in this cycle
cas_bc4  in  1  1=burst chop 4 (2 cycles), 0=BL8 (4 cycles)
rd_delay  in  DELAY_W  read latency in cycles (CL+AL)
wr_delay  in  DELAY_W  write latency in cycles (CWL+AL)
rw_rdy  out  1  one-cycle pulse on the first data cycle of a burst
data_valid  out  1  high on every data cycle of a burst
data_rw  out  1  direction of the current burst (valid while data_valid)
burst_last  out  1  high on the final data cycle of a burst
rw_done  out  1  high when the queue is empty and no burst is active
data_idle  out  1  high when no burst is active
q_count  out  CNT_W  number of queued, not-yet-launched commands
q_full  out  1  q_count==DEPTH
err_late  out  1  sticky: a burst launched after its due cycle
err_ovf  out  1  sticky: a CAS was dropped because the queue was full

Behaviour:
- Reset values (on the edge with reset=1):
  - Queue flushed and q_count=0.
  - rw_rdy, data_valid, data_rw, burst_last, q_full, err_late, err_ovf = 0.
  - rw_done=1, data_idle=1.
- Reset mid-burst: the burst is aborted; outputs take reset values at that edge.
- Push:
  - When cas_rdy=1 in cycle k, the entry {rw, bc4, due} is pushed.
  - Latency is selected by cas_rw and sampled in cycle k. Later changes to rd_delay/wr_delay do not affect queued entries.
  - Effective latency L = max(delay, 2).
  - Due cycle = k+L.
- Per-entry countdown:
  - Loaded with L-1 on push; decremented each cycle, saturating at 0.
  - The head entry is due when its countdown==0.
- Data FSM, two states:
  - D_IDLE: if the head is due, go to D_BURST, assert rw_rdy, pop the head, load beat counter = (bc4 ? 2 : 4).
  - D_BURST: data_valid=1; the beat counter decrements each cycle; burst_last=1 when beat counter==1.
    - On the last beat, if the next head is due in the following cycle, launch seamlessly: stay in D_BURST, pulse rw_rdy next cycle, no gap cycle.
    - Otherwise go to D_IDLE.
- Timing: for CAS in cycle k with L, rw_rdy and the first data_valid occur in cycle k+L; the last data cycle is k+L+1 (BC4) or k+L+3 (BL8).
- Collision: if the head becomes due while a burst is still occupying the bus:
  - Its launch is deferred to the cycle after the current burst_last.
  - err_late is set at that launch.
  - Subsequent entries keep their own countdowns; each one is also deferred and flagged if blocked.
- Ordering: strictly FIFO. Only the head may launch, even if a later entry has a shorter latency. A blocked head causes late launches, flagged by err_late.
- Full:
  - cas_rdy with q_count==DEPTH and no pop in the same cycle: the CAS is dropped and err_ovf is set.
  - Simultaneous push and pop when full: both occur; q_count stays DEPTH.
- Simultaneous push and pop at any count: q_count unchanged.
- Push with an empty queue and idle FSM: rw_done falls in the next cycle.
- rw_done rises the cycle after the final burst_last when the queue is empty.
- err_late and err_ovf clear only on reset.
- Registered outputs throughout; no combinational path from cas_* to the outputs.

Test Plan:
1. Single read: rd_delay=11, BL8, CAS in cycle 10 -> rw_rdy in cycle 21; data_valid in cycles 21-24; burst_last in cycle 24; data_rw=1; rw_done=1 again in cycle 25.
2. Seamless writes: wr_delay=9, BL8 CAS in cycles 5 and 9 -> data_valid continuous over cycles 14-21; rw_rdy in cycles 14 and 18; err_late=0.
3. Mixed BC4: rd_delay=11, wr_delay=9; read BC4 in cycle 0, write BL8 in cycle 4 -> read data in cycles 11-12, write data in cycles 13-16, no errors.
4. Collision: rd_delay=11, BL8 CAS in cycles 0 and 2 -> second burst launches in cycle 15 (due 13); err_late=1.
5. Overflow: DEPTH=8, rd_delay=40, 9 CAS in consecutive cycles -> q_full after 8; 9th CAS dropped; err_ovf=1; exactly 8 bursts follow.
6. Latency change and reset: queue a read with rd_delay=11, change rd_delay to 20 next cycle -> first burst still at +11. Assert reset mid-burst -> data_valid=0, q_count=0, rw_done=1 at the next edge.

Source files
------------

// File: rtl/burst_rw_sched.sv
// -----------------------------------------------------------------------------
// burst_rw_sched
//   CAS-to-data timing scheduler for the DDR4 controller data path.
//   Each accepted CAS gets its own countdown, loaded from the read or write
//   latency that was present when the CAS was accepted. The queue releases
//   entries strictly in FIFO order. Each release starts one data burst of
//   2 cycles (BC4) or 4 cycles (BL8). A burst can follow the previous one
//   with no gap cycle.
//
// Parameters
//   DEPTH    max outstanding CAS commands (power of 2, 2..32)
//   DELAY_W  width of the latency inputs and of each entry countdown
//   CNT_W    width of q_count (must be able to hold DEPTH)
//
// Ports
//   clock_t     controller / data-bus clock
//   reset       synchronous, active-high
//   cas_rdy     one-cycle pulse: CAS issued this cycle
//   cas_rw      1 = READ, 0 = WRITE
//   cas_bc4     1 = burst chop 4 (2 cycles), 0 = BL8 (4 cycles)
//   rd_delay    read latency in cycles (CL+AL)
//   wr_delay    write latency in cycles (CWL+AL)
//   rw_rdy      pulse on the first data cycle of a burst
//   data_valid  high on every data cycle of a burst
//   data_rw     direction of the current burst
//   burst_last  high on the final data cycle of a burst
//   rw_done     queue empty and no burst active
//   data_idle   no burst active
//   q_count     queued, not-yet-launched commands
//   q_full      q_count == DEPTH
//   err_late    sticky: a burst launched after its due cycle
//   err_ovf     sticky: a CAS was dropped because the queue was full
// -----------------------------------------------------------------------------
module burst_rw_sched #(
  parameter int DEPTH   = 8,
  parameter int DELAY_W = 6,
  parameter int CNT_W   = 4
) (
  input  logic               clock_t,
  input  logic               reset,
  input  logic               cas_rdy,
  input  logic               cas_rw,
  input  logic               cas_bc4,
  input  logic [DELAY_W-1:0] rd_delay,
  input  logic [DELAY_W-1:0] wr_delay,
  output logic               rw_rdy,
  output logic               data_valid,
  output logic               data_rw,
  output logic               burst_last,
  output logic               rw_done,
  output logic               data_idle,
  output logic [CNT_W-1:0]   q_count,
  output logic               q_full,
  output logic               err_late,
  output logic               err_ovf
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {D_IDLE, D_BURST} state_t;

  // Queue storage: direction, burst chop and the remaining countdown
  logic               ent_rw  [DEPTH];
  logic               ent_bc4 [DEPTH];
  logic [DELAY_W-1:0] ent_cnt [DEPTH];

  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  state_t             state, state_nx;
  logic [2:0]         beat_q, beat_nx;   // beats left, including the current one
  logic               rw_nx;

  logic               head_due, bus_free, pop, push, ovf;
  logic [DELAY_W-1:0] sel_delay, eff_delay, load_cnt;
  logic [CNT_W-1:0]   count_nx;
  logic [DELAY_W-1:0] head_cnt;

  assign head_cnt = ent_cnt[rd_ptr];

  // The countdown of the head reaches 0 in the cycle in which its data is due.
  // Outputs are registered, so the launch is decided one cycle earlier, while
  // the countdown is still 1. A countdown already at 0 means the due cycle has
  // passed and the launch is late.
  assign head_due = (q_count != '0) && (head_cnt <= DELAY_W'(1));

  // The bus is free in the next cycle when it is idle now or on its last beat
  assign bus_free = (state == D_IDLE) || (beat_q == 3'd1);

  // NOTE: every signal driven in always_comb gets a default first, so that no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pop       = head_due && bus_free;
    push      = cas_rdy && ((q_count != FULL_CNT) || pop);
    ovf       = cas_rdy && (q_count == FULL_CNT) && !pop;

    sel_delay = cas_rw ? rd_delay : wr_delay;
    eff_delay = (sel_delay < DELAY_W'(2)) ? DELAY_W'(2) : sel_delay;
    load_cnt  = eff_delay - DELAY_W'(1);

    count_nx  = q_count;
    case ({push, pop})
      2'b10:   count_nx = q_count + CNT_W'(1);
      2'b01:   count_nx = q_count - CNT_W'(1);
      default: count_nx = q_count;
    endcase

    state_nx  = state;
    beat_nx   = beat_q;
    rw_nx     = data_rw;
    if (pop) begin
      state_nx = D_BURST;
      beat_nx  = ent_bc4[rd_ptr] ? 3'd2 : 3'd4;
      rw_nx    = ent_rw[rd_ptr];
    end else if ((state == D_BURST) && (beat_q > 3'd1)) begin
      beat_nx  = beat_q - 3'd1;
    end else begin
      state_nx = D_IDLE;
      beat_nx  = 3'd0;
      rw_nx    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge whatever the order of the statements.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      state  <= D_IDLE;
      beat_q <= 3'd0;
    end else begin
      state  <= state_nx;
      beat_q <= beat_nx;
    end
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      q_count    <= '0;
      rw_rdy     <= 1'b0;
      data_valid <= 1'b0;
      data_rw    <= 1'b0;
      burst_last <= 1'b0;
      rw_done    <= 1'b1;
      data_idle  <= 1'b1;
      q_full     <= 1'b0;
      err_late   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      q_count    <= count_nx;
      rw_rdy     <= pop;
      data_valid <= (state_nx == D_BURST);
      data_rw    <= rw_nx;
      burst_last <= (state_nx == D_BURST) && (beat_nx == 3'd1);
      rw_done    <= (state_nx == D_IDLE) && (count_nx == '0);
      data_idle  <= (state_nx == D_IDLE);
      q_full     <= (count_nx == FULL_CNT);
      err_late   <= err_late || (pop && (head_cnt == '0));
      err_ovf    <= err_ovf || ovf;
    end
  end

  // NOTE: the queue storage has no reset. An entry is only read after it has
  // been written, and the pointers and count (which are reset) decide validity.
  // When the queue is full, a push and a pop in the same cycle use the same
  // slot. The head is read before the edge and overwritten at the edge.
  always_ff @(posedge clock_t) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr == PTR_W'(i))) begin
        ent_rw[i]  <= cas_rw;
        ent_bc4[i] <= cas_bc4;
        ent_cnt[i] <= load_cnt;
      end else if (ent_cnt[i] != '0) begin
        ent_cnt[i] <= ent_cnt[i] - DELAY_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_burst_rw_sched.sv
// -----------------------------------------------------------------------------
// tb_burst_rw_sched
//   Scoreboard bench for burst_rw_sched. The driver issues CAS commands and
//   computes each command's launch cycle from the latency rules. The launch
//   cycle is the later of the due cycle and the cycle after the previous
//   burst ends. The driver pushes that cycle onto a queue. The monitor samples
//   on the falling edge, pops expectations on rw_rdy, and checks every data
//   beat. It also checks the queue and status outputs in every cycle.
// -----------------------------------------------------------------------------
module tb_burst_rw_sched;

  localparam int DEPTH   = 8;
  localparam int DELAY_W = 6;
  localparam int CNT_W   = 4;

  logic               clock_t  = 1'b0;
  logic               reset    = 1'b1;
  logic               cas_rdy  = 1'b0;
  logic               cas_rw   = 1'b0;
  logic               cas_bc4  = 1'b0;
  logic [DELAY_W-1:0] rd_delay = 6'd11;
  logic [DELAY_W-1:0] wr_delay = 6'd9;
  logic               rw_rdy, data_valid, data_rw, burst_last;
  logic               rw_done, data_idle, q_full, err_late, err_ovf;
  logic [CNT_W-1:0]   q_count;

  burst_rw_sched #(.DEPTH(DEPTH), .DELAY_W(DELAY_W), .CNT_W(CNT_W)) dut (
    .clock_t    (clock_t),
    .reset      (reset),
    .cas_rdy    (cas_rdy),
    .cas_rw     (cas_rw),
    .cas_bc4    (cas_bc4),
    .rd_delay   (rd_delay),
    .wr_delay   (wr_delay),
    .rw_rdy     (rw_rdy),
    .data_valid (data_valid),
    .data_rw    (data_rw),
    .burst_last (burst_last),
    .rw_done    (rw_done),
    .data_idle  (data_idle),
    .q_count    (q_count),
    .q_full     (q_full),
    .err_late   (err_late),
    .err_ovf    (err_ovf)
  );

  always #5 clock_t = ~clock_t;

  // Cycle n is the period that starts at the n-th rising edge
  int cyc = 0;
  always @(posedge clock_t) cyc <= cyc + 1;

  typedef struct {
    int push;    // cycle in which the CAS was issued
    int start;   // first data cycle
    int fin;     // last data cycle
    bit rw;
    bit bc4;
    bit late;
  } cmd_t;

  cmd_t all_q[$];     // every accepted command since the last reset
  cmd_t exp_q[$];     // launches not yet seen by the monitor
  int   launch_log[$];
  int   last_end  = -1;
  int   late_from = -1;
  int   ovf_from  = -1;
  int   n_checks  = 0;
  int   n_err     = 0;
  int   beats_left = 0;
  bit   cur_rw    = 1'b0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Commands that are accepted but not yet launched during cycle m
  function automatic int model_count(int m);
    int n = 0;
    foreach (all_q[i]) if (all_q[i].push < m && all_q[i].start > m) n++;
    return n;
  endfunction

  function automatic bit model_busy(int m);
    foreach (all_q[i]) if (all_q[i].start <= m && m <= all_q[i].fin) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_pop_at(int m);
    foreach (all_q[i]) if (all_q[i].start == m) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic step();
    @(posedge clock_t);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cas(bit rw, bit bc4);
    int   k   = cyc;
    int   dly = rw ? int'(rd_delay) : int'(wr_delay);
    int   lat = (dly < 2) ? 2 : dly;
    cmd_t c;
    cas_rdy = 1'b1;
    cas_rw  = rw;
    cas_bc4 = bc4;
    if (model_count(k) == DEPTH && !model_pop_at(k + 1)) begin
      if (ovf_from < 0) ovf_from = k + 1;
    end else begin
      c.push  = k;
      c.start = (k + lat > last_end + 1) ? k + lat : last_end + 1;
      c.fin   = c.start + (bc4 ? 1 : 3);
      c.rw    = rw;
      c.bc4   = bc4;
      c.late  = (c.start > k + lat);
      last_end = c.fin;
      if (c.late && late_from < 0) late_from = c.start;
      all_q.push_back(c);
      exp_q.push_back(c);
    end
    step();
    cas_rdy = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    cas_rdy = 1'b0;
    step();
    reset = 1'b0;
    all_q.delete();
    exp_q.delete();
    launch_log.delete();
    last_end  = -1;
    late_from = -1;
    ovf_from  = -1;
    @(negedge clock_t);
    check("rst_rw_rdy",     int'(rw_rdy),     0);
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_data_rw",    int'(data_rw),    0);
    check("rst_burst_last", int'(burst_last), 0);
    check("rst_q_count",    int'(q_count),    0);
    check("rst_q_full",     int'(q_full),     0);
    check("rst_err_late",   int'(err_late),   0);
    check("rst_err_ovf",    int'(err_ovf),    0);
    check("rst_rw_done",    int'(rw_done),    1);
    check("rst_data_idle",  int'(data_idle),  1);
    step();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || beats_left != 0 || !rw_done) && n < 2000) begin
      step();
      n++;
    end
    check("drain_timeout", int'(n < 2000), 1);
  endtask

  // --------------------------------------------------------------- monitor
  cmd_t mon_e;
  int   mon_m;
  int   mon_cnt;
  bit   mon_busy;

  always @(negedge clock_t) begin
    if (reset) begin
      beats_left = 0;
    end else begin
      mon_m    = cyc;
      mon_cnt  = model_count(mon_m);
      mon_busy = model_busy(mon_m);
      check("q_count",   int'(q_count),   mon_cnt);
      check("q_full",    int'(q_full),    int'(mon_cnt == DEPTH));
      check("data_idle", int'(data_idle), int'(!mon_busy));
      check("rw_done",   int'(rw_done),   int'(!mon_busy && mon_cnt == 0));
      check("err_late",  int'(err_late),  int'(late_from >= 0 && mon_m >= late_from));
      check("err_ovf",   int'(err_ovf),   int'(ovf_from >= 0 && mon_m >= ovf_from));

      if (rw_rdy) begin
        launch_log.push_back(mon_m);
        if (exp_q.size() == 0) begin
          check("rw_rdy_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("launch_cycle", mon_m, mon_e.start);
          check("launch_rw", int'(data_rw), int'(mon_e.rw));
          beats_left = mon_e.bc4 ? 2 : 4;
          cur_rw     = mon_e.rw;
        end
      end else if (exp_q.size() != 0 && exp_q[0].start == mon_m) begin
        mon_e = exp_q.pop_front();
        check("launch_missing", 0, 1);
      end

      if (data_valid) begin
        if (beats_left == 0) begin
          check("valid_outside_burst", 1, 0);
        end else begin
          check("beat_rw", int'(data_rw), int'(cur_rw));
          check("burst_last", int'(burst_last), int'(beats_left == 1));
          beats_left--;
        end
      end else begin
        if (beats_left != 0) begin
          check("burst_truncated", 0, beats_left);
          beats_left = 0;
        end
        check("burst_last_idle", int'(burst_last), 0);
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    int k;
    idle(2);
    do_reset();

    // Single BL8 read, latency 11
    rd_delay = 6'd11;
    idle(3);
    k = cyc;
    cas(1'b1, 1'b0);
    drain();
    check("t1_launches", launch_log.size(), 1);
    if (launch_log.size() == 1) check("t1_offset", launch_log[0] - k, 11);

    // Seamless BL8 writes, latency 9
    do_reset();
    wr_delay = 6'd9;
    k = cyc;
    cas(1'b0, 1'b0);
    idle(3);
    cas(1'b0, 1'b0);
    drain();
    check("t2_launches", launch_log.size(), 2);
    if (launch_log.size() == 2) begin
      check("t2_first",  launch_log[0] - k, 9);
      check("t2_second", launch_log[1] - k, 13);
    end
    check("t2_err_late", int'(err_late), 0);

    // BC4 read followed by BL8 write
    do_reset();
    rd_delay = 6'd11;
    wr_delay = 6'd9;
    k = cyc;
    cas(1'b1, 1'b1);
    idle(3);
    cas(1'b0, 1'b0);
    drain();
    check("t3_launches", launch_log.size(), 2);
    if (launch_log.size() == 2) begin
      check("t3_read",  launch_log[0] - k, 11);
      check("t3_write", launch_log[1] - k, 13);
    end
    check("t3_err_late", int'(err_late), 0);

    // Collision: the second read is due while the first still holds the bus
    do_reset();
    rd_delay = 6'd11;
    k = cyc;
    cas(1'b1, 1'b0);
    idle(1);
    cas(1'b1, 1'b0);
    drain();
    check("t4_launches", launch_log.size(), 2);
    if (launch_log.size() == 2) check("t4_deferred", launch_log[1] - k, 15);
    check("t4_err_late", int'(err_late), 1);

    // Overflow: nine back-to-back reads into an eight-deep queue
    do_reset();
    rd_delay = 6'd40;
    for (int i = 0; i < 9; i++) cas(1'b1, 1'b0);
    check("t5_q_full", int'(q_full), 1);
    drain();
    check("t5_launches", launch_log.size(), 8);
    check("t5_err_ovf", int'(err_ovf), 1);

    // The latency is sampled when the CAS is accepted; reset aborts a burst
    do_reset();
    rd_delay = 6'd11;
    k = cyc;
    cas(1'b1, 1'b0);
    rd_delay = 6'd20;
    idle(1);
    cas(1'b1, 1'b0);
    idle(k + 12 - cyc);
    check("t6_launches", launch_log.size(), 1);
    if (launch_log.size() == 1) check("t6_offset", launch_log[0] - k, 11);
    check("t6_mid_burst", int'(data_valid), 1);
    do_reset();

    // Random traffic with latencies that change every cycle
    for (int n = 0; n < 400; n++) begin
      rd_delay = DELAY_W'($urandom_range(0, 24));
      wr_delay = DELAY_W'($urandom_range(0, 20));
      cas(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) begin
        for (int g = int'($urandom_range(0, 7)); g > 0; g--) begin
          rd_delay = DELAY_W'($urandom_range(0, 24));
          wr_delay = DELAY_W'($urandom_range(0, 20));
          step();
        end
      end
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
